// File: rtl/keypad_pkg.sv
// Shared types, key code constants and the row/column to key code map
// for the keypad scan and debounce block.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHECK,
        HELD,
        RELEASE_CHECK
    } key_state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } scan_result_e;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_CLR   = 4'hE;
    localparam logic [3:0] KEY_DP    = 4'hF;

    // Physical layout: rows top to bottom, columns left to right.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_PLUS;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_MINUS;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_DP;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_CLR;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix pins plus the key event outputs seen by the calculator FSM.
interface keypad_scan_debounce_if;

    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_pressed;

    // slave is the scanner; master is the keypad/consumer side.
    modport slave (
        input  row_in,
        output col_out,
        output key_valid,
        output key_code,
        output key_pressed
    );

    modport master (
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code,
        input  key_pressed
    );

endinterface

// File: rtl/keypad_scan_sequencer.sv
// Synchronizes the rows, walks the one-hot column drive and classifies each
// full matrix scan as NONE, SINGLE(code) or MULTI.
module keypad_scan_sequencer
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   row_in,
    output logic [3:0]   col_out,
    output logic         scan_done,
    output scan_result_e scan_result,
    output logic [3:0]   scan_code
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [1:0]    hit_cnt;
    logic [3:0]    hit_code;

    logic          sample;
    logic [2:0]    pop;
    logic [2:0]    total;
    logic [1:0]    row_idx;
    logic [3:0]    sample_code;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign col_out   = 4'b0001 << col_idx;
    assign sample    = (dwell == DWELL_LAST);
    assign scan_done = sample && (col_idx == 2'd3);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pop     = '0;
        row_idx = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_sync[r]) begin
                pop     = pop + 3'd1;
                row_idx = 2'(r);
            end
        end
    end

    assign sample_code = key_map(row_idx, col_idx);
    assign total       = {1'b0, hit_cnt} + pop;

    // The column-3 sample is folded in combinationally so the verdict is
    // ready on the scan_done cycle itself.
    always_comb begin
        scan_result = NONE;
        scan_code   = hit_code;
        if (total == 3'd1) begin
            scan_result = SINGLE;
            if (pop == 3'd1) scan_code = sample_code;
        end else if (total >= 3'd2) begin
            scan_result = MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            hit_code <= '0;
        end else if (sample) begin
            if (col_idx == 2'd3) begin
                hit_cnt  <= '0;
                hit_code <= '0;
            end else begin
                hit_cnt <= (total >= 3'd2) ? 2'd2 : total[1:0];
                if (pop == 3'd1) hit_code <= sample_code;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Keypad front end: matrix scanning plus a press/release debounce FSM that
// emits one key_valid pulse per clean press and a debounced key_pressed level.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_scan_debounce_if.slave bus
);

    localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic         scan_done;
    scan_result_e scan_result;
    logic [3:0]   scan_code;
    logic [3:0]   col_drive;

    key_state_e   state;
    logic [3:0]   cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_pressed;

    keypad_scan_sequencer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .row_in      (bus.row_in),
        .col_out     (col_drive),
        .scan_done   (scan_done),
        .scan_result (scan_result),
        .scan_code   (scan_code)
    );

    // Saturating so a long stable run never wraps back below the threshold.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_result == SINGLE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                key_valid   <= 1'b1;
                                key_code    <= scan_code;
                                key_pressed <= 1'b1;
                                cnt         <= '0;
                                state       <= HELD;
                            end else begin
                                cand  <= scan_code;
                                cnt   <= CW'(1);
                                state <= PRESS_CHECK;
                            end
                        end
                    end
                    PRESS_CHECK: begin
                        if (scan_result == SINGLE && scan_code == cand) begin
                            if (cnt_inc == CNT_MAX) begin
                                key_valid   <= 1'b1;
                                key_code    <= cand;
                                key_pressed <= 1'b1;
                                cnt         <= '0;
                                state       <= HELD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // A different verdict abandons the candidate; a new
                            // one is only taken on the following scan.
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (scan_result == NONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                key_pressed <= 1'b0;
                                state       <= IDLE;
                            end else begin
                                cnt   <= CW'(1);
                                state <= RELEASE_CHECK;
                            end
                        end
                    end
                    RELEASE_CHECK: begin
                        if (scan_result == NONE) begin
                            if (cnt_inc == CNT_MAX) begin
                                key_pressed <= 1'b0;
                                cnt         <= '0;
                                state       <= IDLE;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= HELD;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.col_out     = col_drive;
    assign bus.key_valid   = key_valid;
    assign bus.key_code    = key_code;
    assign bus.key_pressed = key_pressed;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Drives a behavioural keypad matrix scan by scan and compares every cycle's
// outputs with a run-length debounce model built from the key layout table.
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 2;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keypad_scan_debounce_if bus ();

    keypad_scan_debounce #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Key codes in row-major order, index = row*4 + col.
    int key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};

    bit         m_held;
    bit         m_event;
    int         m_run;
    int         m_cand;
    logic [3:0] m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic model_reset();
        m_held  = 1'b0;
        m_event = 1'b0;
        m_run   = 0;
        m_cand  = 0;
        m_code  = '0;
    endtask

    // One whole scan with the key set k held steady.
    task automatic model_scan(input logic [15:0] k);
        int n;
        int code;
        n    = $countones(k);
        code = -1;
        for (int i = 0; i < 16; i++) if (k[i]) code = key_tab[i];
        m_event = 1'b0;
        if (!m_held) begin
            if (m_run == 0) begin
                if (n == 1) begin
                    m_cand = code;
                    m_run  = 1;
                end
            end else if (n == 1 && code == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == DS) begin
                m_event = 1'b1;
                m_held  = 1'b1;
                m_code  = 4'(m_cand);
                m_run   = 0;
            end
        end else begin
            if (n == 0) m_run++;
            else        m_run = 0;
            if (m_run == DS) begin
                m_held = 1'b0;
                m_run  = 0;
            end
        end
    endtask

    task automatic drive_rows(input logic [15:0] k);
        logic [3:0] rows;
        rows = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (bus.col_out[c] && k[r * 4 + c]) rows[r] = 1'b1;
        bus.row_in = rows;
    endtask

    task automatic tick_check(input logic [15:0] k, input int phase);
        drive_rows(k);
        check("col_out",     32'(bus.col_out),     32'(1) << (phase / SCAN_DIV));
        check("key_valid",   32'(bus.key_valid),   32'(phase == 0 && m_event));
        check("key_pressed", 32'(bus.key_pressed), 32'(m_held));
        check("key_code",    32'(bus.key_code),    32'(m_code));
        @(negedge clk);
    endtask

    task automatic run_scan(input logic [15:0] k);
        for (int p = 0; p < SCAN_CYC; p++) tick_check(k, p);
        model_scan(k);
    endtask

    task automatic run_scans(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_scan(k);
    endtask

    // Partial scan, then a one-cycle reset; the partial scan is discarded.
    task automatic reset_mid(input logic [15:0] k, input int p0);
        for (int p = 0; p < p0; p++) tick_check(k, p);
        drive_rows(k);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] k5, ke, kd, k1, k2, keys;
        int          sel;

        k5 = key_bit(1, 1);
        ke = key_bit(3, 2);
        kd = key_bit(3, 3);
        k1 = key_bit(0, 0);
        k2 = key_bit(0, 1);

        rst        = 1'b1;
        bus.row_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_scans('0, 2);                      // idle column walk
        run_scans(k5, 10);                     // stable '5'
        run_scan('0); run_scan(k5);            // release glitch while held
        run_scans('0, 3);
        run_scan(ke); run_scan('0);            // bouncing 'E'
        run_scans(ke, 4); run_scans('0, 3);
        run_scans(k1 | k2, 5);                 // two keys: rejected
        run_scans(k1, 4); run_scans('0, 3);
        run_scan(kd);                          // 'D' reaches PRESS_CHECK
        reset_mid(kd, $urandom_range(1, SCAN_CYC - 1));
        run_scans(kd, 4); run_scans('0, 3);

        keys = '0;
        for (int s = 0; s < 200; s++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 9)      keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3))
                                    | key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            else if (sel >= 7) keys = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
            else if (sel >= 5) keys = '0;
            if ($urandom_range(0, 29) == 0) reset_mid(keys, $urandom_range(1, SCAN_CYC - 1));
            else                            run_scan(keys);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
